// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner select for a shared tristate bus.
// Drives complementary EN/EN_BAR pairs with enforced dead time between owners.
module tristate_bus_arbiter #(
  parameter int N       = 4,
  parameter int DEAD    = 2,
  parameter int MAXHOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [N-1:0]         REQ,
  output logic [N-1:0]         GNT,
  output logic [N-1:0]         EN,
  output logic [N-1:0]         EN_BAR,
  output logic [$clog2(N)-1:0] OWNER,
  output logic                 BUS_IDLE
);

  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [W-1:0]   ptr;
  logic [W-1:0]   ptr_nx;
  logic [W-1:0]   owner_nx;
  logic [W-1:0]   win;
  logic [W-1:0]   idx;
  logic           found;
  logic [4:0]     hold;
  logic [4:0]     hold_nx;
  logic [3:0]     dead;
  logic [3:0]     dead_nx;
  logic [N-1:0]   en_nx;
  logic [N-1:0]   others;
  logic           lim;

  // First requester at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!found && REQ[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    others        = REQ;
    others[OWNER] = 1'b0;
    lim = (MAXHOLD != 0) && (hold == 5'(MAXHOLD)) && (|others);
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = OWNER;
    hold_nx  = hold;
    dead_nx  = dead;
    en_nx    = EN;
    unique case (state)
      IDLE: begin
        en_nx = '0;
        if (found) begin
          en_nx[win] = 1'b1;
          owner_nx   = win;
          hold_nx    = 5'd1;
          state_nx   = DRIVE;
        end
      end
      DRIVE: begin
        if (!REQ[OWNER] || lim) begin
          en_nx    = '0;
          ptr_nx   = (OWNER == W'(N - 1)) ? '0 : OWNER + 1'b1;
          dead_nx  = 4'd1;
          state_nx = TURN;
        end else if (hold != 5'(MAXHOLD) && hold != 5'd31) begin
          // Unlimited mode saturates at the counter top instead of wrapping.
          hold_nx = hold + 5'd1;
        end
      end
      TURN: begin
        en_nx = '0;
        if (dead == 4'(DEAD)) begin
          dead_nx  = '0;
          state_nx = IDLE;
          if (found) begin
            en_nx[win] = 1'b1;
            owner_nx   = win;
            hold_nx    = 5'd1;
            state_nx   = DRIVE;
          end
        end else begin
          dead_nx = dead + 4'd1;
        end
      end
      default: begin
        en_nx    = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      ptr      <= '0;
      OWNER    <= '0;
      hold     <= '0;
      dead     <= '0;
      EN       <= '0;
      EN_BAR   <= '1;
      BUS_IDLE <= 1'b1;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      OWNER    <= owner_nx;
      hold     <= hold_nx;
      dead     <= dead_nx;
      EN       <= en_nx;
      EN_BAR   <= ~en_nx;
      BUS_IDLE <= ~(|en_nx);
    end
  end

  assign GNT = EN;

endmodule
